prog_control_unit: RTL and testbench



---
 rtl/prog_control_unit_if.sv | 44 ++++
 rtl/prog_control_unit.sv | 204 ++++++++++++++++++++
 tb/tb_prog_control_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_control_unit_if.sv
// Host/datapath-side signal bundle of the programmable SimpleCPU control unit.
interface prog_control_unit_if #(
  parameter int unsigned FIELD_W = 4,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned INSTR_W = 4 + 4 * FIELD_W;

  logic               start;
  logic               step_mode;
  logic               step;
  logic               zero_flag;
  logic               equal_flag;
  logic               greater_flag;
  logic               prog_we;
  logic [FIELD_W-1:0] prog_addr;
  logic [INSTR_W-1:0] prog_data;

  logic [3:0]         opcode;
  logic [FIELD_W-1:0] reg_a_sel;
  logic [FIELD_W-1:0] reg_b_sel;
  logic [FIELD_W-1:0] dest_reg;
  logic               reg_write;
  logic               load_operands;
  logic [FIELD_W-1:0] pc;
  logic               busy;
  logic               done;
  logic               error;
  logic [2:0]         err_code;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output start, step_mode, step, zero_flag, equal_flag, greater_flag,
           prog_we, prog_addr, prog_data,
    input  opcode, reg_a_sel, reg_b_sel, dest_reg, reg_write, load_operands,
           pc, busy, done, error, err_code, instr_count
  );

  modport slave (
    input  start, step_mode, step, zero_flag, equal_flag, greater_flag,
           prog_we, prog_addr, prog_data,
    output opcode, reg_a_sel, reg_b_sel, dest_reg, reg_write, load_operands,
           pc, busy, done, error, err_code, instr_count
  );
endinterface

// File: rtl/prog_control_unit.sv
// Programmable FETCH/EXECUTE sequencer for the SimpleCPU datapath with a return
// stack, zero-flag branch, single-step, instruction watchdog and error report.
module prog_control_unit #(
  parameter int unsigned FIELD_W      = 4,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned MAX_INSTR    = 0,
  parameter int unsigned CNT_W        = 16,
  parameter string       PROGRAM_FILE = "program.mem"
) (
  input logic                clk,
  input logic                rst_n,
  prog_control_unit_if.slave bus
);
  localparam int unsigned INSTR_W = 4 + 4 * FIELD_W;
  localparam int unsigned DEPTH   = 2 ** FIELD_W;
  localparam int unsigned SP_W    = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_BGT  = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;
  localparam logic [3:0] OP_BZ   = 4'd8;
  localparam logic [3:0] OP_CALL = 4'd9;
  localparam logic [3:0] OP_RET  = 4'd10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_EXEC, S_HOLD, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [FIELD_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, dest_q, dest_d, d2_q, d2_d;
  logic [3:0]         opc_q, opc_d;
  logic               rw_q, rw_d, lo_q, lo_d, busy_q, busy_d;
  logic               done_q, done_d, err_q, err_d;
  logic [2:0]         code_q, code_d, fault;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [FIELD_W-1:0] next_pc;
  logic               push, wd_hit;

  logic [INSTR_W-1:0] imem   [DEPTH];
  logic [FIELD_W-1:0] rstack [STACK_DEPTH];
  logic [INSTR_W-1:0] word;

  assign word    = imem[pc_q];
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign wd_hit  = (MAX_INSTR != 0) && (cnt_inc == CNT_W'(MAX_INSTR));
  assign busy_d  = state_d inside {S_LOAD, S_FETCH, S_EXEC, S_HOLD};

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    dest_d  = dest_q;
    d2_d    = d2_q;
    rw_d    = rw_q;
    lo_d    = lo_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    push    = 1'b0;
    next_pc = d2_q;
    fault   = 3'd0;

    case (state_q)
      S_IDLE, S_DONE: begin
        rw_d = 1'b0;
        if (bus.start) begin
          lo_d    = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 3'd0;
          cnt_d   = '0;
          sp_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        lo_d    = 1'b0;
        pc_d    = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        opc_d   = word[INSTR_W-1 -: 4];
        a_d     = word[4*FIELD_W-1 -: FIELD_W];
        b_d     = word[3*FIELD_W-1 -: FIELD_W];
        dest_d  = word[2*FIELD_W-1 -: FIELD_W];
        d2_d    = word[FIELD_W-1:0];
        rw_d    = 1'b0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = cnt_inc;
        case (opc_q)
          OP_BGT:  next_pc = bus.greater_flag ? dest_q : d2_q;
          OP_BEQ:  next_pc = bus.equal_flag ? dest_q : d2_q;
          OP_BZ:   next_pc = bus.zero_flag ? dest_q : d2_q;
          OP_CALL: next_pc = dest_q;
          OP_RET:  next_pc = rstack[IDX_W'(sp_q - SP_W'(1))];
          default: next_pc = d2_q;
        endcase
        if (opc_q > OP_RET)                                  fault = 3'd3;
        else if (opc_q == OP_CALL && sp_q == SP_W'(STACK_DEPTH)) fault = 3'd1;
        else if (opc_q == OP_RET && sp_q == '0)              fault = 3'd2;

        if (fault != 3'd0) begin
          // Faulting instruction has no side effects; pc stays on it
          done_d  = 1'b1;
          err_d   = 1'b1;
          code_d  = fault;
          state_d = S_DONE;
        end else begin
          pc_d = (opc_q == OP_HALT) ? pc_q : next_pc;
          rw_d = (opc_q <= OP_MOV);
          if (opc_q == OP_CALL) begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end
          if (opc_q == OP_RET) sp_d = sp_q - SP_W'(1);
          if (opc_q == OP_HALT) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (wd_hit) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            code_d  = 3'd4;
            state_d = S_DONE;
          end else begin
            state_d = bus.step_mode ? S_HOLD : S_FETCH;
          end
        end
      end
      S_HOLD: begin
        rw_d = 1'b0;
        if (bus.step || !bus.step_mode) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dest_q  <= '0;
      d2_q    <= '0;
      rw_q    <= 1'b0;
      lo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      cnt_q   <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dest_q  <= dest_d;
      d2_q    <= d2_d;
      rw_q    <= rw_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
    end
  end

  // Return stack and program RAM keep their contents across resets
  always_ff @(posedge clk) begin
    if (push) rstack[IDX_W'(sp_q)] <= d2_q;
  end

  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q == S_IDLE || state_q == S_DONE))
      imem[bus.prog_addr] <= bus.prog_data;
  end

  assign bus.opcode        = opc_q;
  assign bus.reg_a_sel     = a_q;
  assign bus.reg_b_sel     = b_q;
  assign bus.dest_reg      = dest_q;
  assign bus.reg_write     = rw_q;
  assign bus.load_operands = lo_q;
  assign bus.pc            = pc_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = err_q;
  assign bus.err_code      = code_q;
  assign bus.instr_count   = cnt_q;
endmodule

// File: tb/tb_prog_control_unit.sv
// Self-checking bench: an ISA-level interpreter predicts every cycle of a run,
// plus directed literal checks for step mode, RAM write gating and reset.
module tb_prog_control_unit;
  localparam int unsigned FW = 4;
  localparam int unsigned CW = 16;
  localparam int STK = 4;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  prog_control_unit_if #(.FIELD_W(FW), .CNT_W(CW)) bus_m ();
  prog_control_unit_if #(.FIELD_W(FW), .CNT_W(CW)) bus_w ();

  prog_control_unit #(.FIELD_W(FW), .STACK_DEPTH(STK), .MAX_INSTR(0), .CNT_W(CW),
                      .PROGRAM_FILE("")) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  prog_control_unit #(.FIELD_W(FW), .STACK_DEPTH(STK), .MAX_INSTR(3), .CNT_W(CW),
                      .PROGRAM_FILE("")) u_wd  (.clk(clk), .rst_n(rst_n), .bus(bus_w));

  assign bus_w.start        = bus_m.start;
  assign bus_w.step_mode    = bus_m.step_mode;
  assign bus_w.step         = bus_m.step;
  assign bus_w.zero_flag    = bus_m.zero_flag;
  assign bus_w.equal_flag   = bus_m.equal_flag;
  assign bus_w.greater_flag = bus_m.greater_flag;
  assign bus_w.prog_we      = bus_m.prog_we;
  assign bus_w.prog_addr    = bus_m.prog_addr;
  assign bus_w.prog_data    = bus_m.prog_data;

  // Observed outputs of whichever instance the current run targets
  bit         use_wd;
  logic [3:0] o_pc, o_opc, o_ra, o_rb, o_dest;
  logic       o_busy, o_done, o_err, o_rw, o_lo;
  logic [2:0] o_code;
  logic [CW-1:0] o_cnt;
  assign o_pc   = use_wd ? bus_w.pc            : bus_m.pc;
  assign o_opc  = use_wd ? bus_w.opcode        : bus_m.opcode;
  assign o_ra   = use_wd ? bus_w.reg_a_sel     : bus_m.reg_a_sel;
  assign o_rb   = use_wd ? bus_w.reg_b_sel     : bus_m.reg_b_sel;
  assign o_dest = use_wd ? bus_w.dest_reg      : bus_m.dest_reg;
  assign o_busy = use_wd ? bus_w.busy          : bus_m.busy;
  assign o_done = use_wd ? bus_w.done          : bus_m.done;
  assign o_err  = use_wd ? bus_w.error         : bus_m.error;
  assign o_rw   = use_wd ? bus_w.reg_write     : bus_m.reg_write;
  assign o_lo   = use_wd ? bus_w.load_operands : bus_m.load_operands;
  assign o_code = use_wd ? bus_w.err_code      : bus_m.err_code;
  assign o_cnt  = use_wd ? bus_w.instr_count   : bus_m.instr_count;

  typedef struct {
    bit pc_chk; logic [3:0] pc; bit busy; bit done; bit err; logic [2:0] code;
    int cnt; bit rw; bit lo; bit ex; logic [3:0] opc; logic [3:0] ra; logic [3:0] rb; logic [3:0] d;
  } exp_t;

  exp_t        exq[$];
  exp_t        cx;
  logic [19:0] tmem[16];
  int          checks, errors, chk_idx, rw_pulses;
  bit          chk_on;

  function automatic logic [19:0] ins(input int opc, input int a, input int b, input int d1, input int d2);
    return {4'(opc), 4'(a), 4'(b), 4'(d1), 4'(d2)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ISA interpreter: one entry per cycle from the start edge to one cycle after done
  task automatic build(input bit g, input bit eq, input bit z, input int maxi);
    exp_t c; int stk[$]; int pcm, opc, d1, d2, nxt, code; logic [19:0] w; bit alu;
    exq.delete();
    c.pc_chk = 0; c.pc = 0; c.busy = 1; c.done = 0; c.err = 0; c.code = 0; c.cnt = 0;
    c.rw = 0; c.lo = 1; c.ex = 0; c.opc = 0; c.ra = 0; c.rb = 0; c.d = 0;
    exq.push_back(c);
    c.pc_chk = 1; c.lo = 0;
    exq.push_back(c);
    pcm = 0;
    for (int i = 0; i < 40; i++) begin
      w = tmem[pcm];
      opc = int'(w[19:16]); d1 = int'(w[7:4]); d2 = int'(w[3:0]);
      c.ex = 1; c.rw = 0; c.cnt = i; c.pc = 4'(pcm);
      c.opc = w[19:16]; c.ra = w[15:12]; c.rb = w[11:8]; c.d = w[7:4];
      exq.push_back(c);
      c.ex = 0; c.cnt = i + 1;
      code = (opc > 10) ? 3 : (opc == 9 && stk.size() == STK) ? 1 : (opc == 10 && stk.size() == 0) ? 2 : 0;
      alu = (opc <= 4);
      nxt = d2;
      if (opc == 5) nxt = g ? d1 : d2;
      if (opc == 6) nxt = eq ? d1 : d2;
      if (opc == 8) nxt = z ? d1 : d2;
      if (opc == 9) nxt = d1;
      if (opc == 10 && stk.size() > 0) nxt = stk[$];
      if (code != 0 || opc == 7) begin
        c.busy = 0; c.done = 1; c.err = (code != 0); c.code = 3'(code);
        exq.push_back(c); exq.push_back(c);
        return;
      end
      if (opc == 9) stk.push_back(d2);
      if (opc == 10) void'(stk.pop_back());
      c.pc = 4'(nxt); c.rw = alu;
      if (maxi != 0 && i + 1 == maxi) begin
        c.busy = 0; c.done = 1; c.err = 1; c.code = 3'd4;
        exq.push_back(c);
        c.rw = 0;
        exq.push_back(c);
        return;
      end
      exq.push_back(c);
      pcm = nxt;
    end
  endtask

  // Per-cycle comparison against the interpreter's prediction
  always @(negedge clk) begin
    if (chk_on) begin
      cx = exq[chk_idx];
      if (cx.pc_chk) chk($sformatf("pc@%0d", chk_idx), 64'(o_pc), 64'(cx.pc));
      chk($sformatf("busy@%0d", chk_idx), 64'(o_busy), 64'(cx.busy));
      chk($sformatf("done@%0d", chk_idx), 64'(o_done), 64'(cx.done));
      chk($sformatf("error@%0d", chk_idx), 64'(o_err), 64'(cx.err));
      chk($sformatf("err_code@%0d", chk_idx), 64'(o_code), 64'(cx.code));
      chk($sformatf("count@%0d", chk_idx), 64'(o_cnt), 64'(cx.cnt));
      chk($sformatf("reg_write@%0d", chk_idx), 64'(o_rw), 64'(cx.rw));
      chk($sformatf("load_op@%0d", chk_idx), 64'(o_lo), 64'(cx.lo));
      if (cx.ex) begin
        chk($sformatf("opcode@%0d", chk_idx), 64'(o_opc), 64'(cx.opc));
        chk($sformatf("reg_a@%0d", chk_idx), 64'(o_ra), 64'(cx.ra));
        chk($sformatf("reg_b@%0d", chk_idx), 64'(o_rb), 64'(cx.rb));
      end
      if (cx.ex || cx.rw) chk($sformatf("dest@%0d", chk_idx), 64'(o_dest), 64'(cx.d));
      chk_idx++;
      if (chk_idx >= exq.size()) chk_on = 0;
    end
  end

  always @(negedge clk) if (o_rw) rw_pulses++;

  task automatic pw(input int addr, input logic [19:0] w, input bit upd);
    @(negedge clk);
    bus_m.prog_we = 1'b1; bus_m.prog_addr = 4'(addr); bus_m.prog_data = w;
    @(posedge clk); #1;
    bus_m.prog_we = 1'b0;
    if (upd) tmem[addr] = w;
  endtask

  task automatic run_prog(input bit g, input bit eq, input bit z, input int maxi);
    bus_m.greater_flag = g; bus_m.equal_flag = eq; bus_m.zero_flag = z;
    build(g, eq, z, maxi);
    @(negedge clk);
    rw_pulses = 0;
    bus_m.start = 1'b1;
    @(posedge clk); #1;
    bus_m.start = 1'b0;
    chk_idx = 0; chk_on = 1;
    for (int k = 0; k < 200; k++) begin
      if (!chk_on) break;
      @(negedge clk); #1;
    end
    if (chk_on) begin
      chk_on = 0;
      chk("run_timeout", 64'(1), 64'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0; use_wd = 0; chk_on = 0; checks = 0; errors = 0; rw_pulses = 0; chk_idx = 0;
    bus_m.start = 0; bus_m.step_mode = 0; bus_m.step = 0;
    bus_m.zero_flag = 0; bus_m.equal_flag = 0; bus_m.greater_flag = 0;
    bus_m.prog_we = 0; bus_m.prog_addr = '0; bus_m.prog_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_pc", 64'(bus_m.pc), 64'(0));
    chk("rst_busy", 64'(bus_m.busy), 64'(0));
    chk("rst_done", 64'(bus_m.done), 64'(0));
    chk("rst_err_code", 64'(bus_m.err_code), 64'(0));
    chk("rst_count", 64'(bus_m.instr_count), 64'(0));
    chk("rst_reg_write", 64'(bus_m.reg_write), 64'(0));
    rst_n = 1'b1;

    // ADD then HALT
    pw(0, ins(0, 1, 2, 3, 1), 1); pw(1, ins(7, 0, 0, 0, 0), 1);
    run_prog(0, 0, 0, 0);
    chk("add_model_len", 64'(exq.size()), 64'(7));
    chk("add_count", 64'(bus_m.instr_count), 64'(2));
    chk("add_rw_pulses", 64'(rw_pulses), 64'(1));
    chk("add_error", 64'(bus_m.error), 64'(0));

    // Flag branches
    pw(0, ins(5, 0, 0, 5, 2), 1); pw(2, ins(7, 0, 0, 0, 0), 1); pw(5, ins(7, 0, 0, 0, 0), 1);
    run_prog(1, 0, 0, 0);  chk("bgt_taken_pc", 64'(bus_m.pc), 64'(5));
    run_prog(0, 0, 0, 0);  chk("bgt_not_pc", 64'(bus_m.pc), 64'(2));
    pw(0, ins(8, 0, 0, 5, 2), 1);
    run_prog(0, 0, 1, 0);  chk("bz_taken_pc", 64'(bus_m.pc), 64'(5));
    run_prog(1, 1, 0, 0);  chk("bz_not_pc", 64'(bus_m.pc), 64'(2));
    pw(0, ins(6, 0, 0, 5, 2), 1);
    run_prog(0, 1, 0, 0);  chk("beq_taken_pc", 64'(bus_m.pc), 64'(5));

    // CALL / RET
    pw(0, ins(9, 0, 0, 4, 1), 1); pw(4, ins(10, 0, 0, 0, 0), 1); pw(1, ins(7, 0, 0, 0, 0), 1);
    run_prog(0, 0, 0, 0);
    chk("call_pc", 64'(bus_m.pc), 64'(1));
    chk("call_error", 64'(bus_m.error), 64'(0));
    pw(0, ins(10, 0, 0, 0, 0), 1);
    run_prog(0, 0, 0, 0);  chk("underflow_code", 64'(bus_m.err_code), 64'(2));
    for (int i = 0; i < 5; i++) pw(i, ins(9, 0, 0, i + 1, 0), 1);
    run_prog(0, 0, 0, 0);
    chk("overflow_code", 64'(bus_m.err_code), 64'(1));
    chk("overflow_pc", 64'(bus_m.pc), 64'(4));

    // Illegal opcode
    pw(0, ins(12, 1, 2, 3, 4), 1);
    run_prog(0, 0, 0, 0);
    chk("illegal_code", 64'(bus_m.err_code), 64'(3));
    chk("illegal_rw_pulses", 64'(rw_pulses), 64'(0));

    // Single step, and a RAM write during the run
    pw(0, ins(0, 1, 2, 3, 1), 1); pw(1, ins(4, 2, 0, 5, 2), 1); pw(2, ins(7, 0, 0, 0, 0), 1);
    bus_m.step_mode = 1'b1;
    @(negedge clk); bus_m.start = 1'b1;
    @(posedge clk); #1; bus_m.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_busy", 64'(bus_m.busy), 64'(1));
    chk("hold_pc", 64'(bus_m.pc), 64'(1));
    chk("hold_rw", 64'(bus_m.reg_write), 64'(1));
    pw(2, ins(12, 0, 0, 0, 0), 0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_stable_pc", 64'(bus_m.pc), 64'(1));
      chk("hold_stable_busy", 64'(bus_m.busy), 64'(1));
    end
    bus_m.step = 1'b1;
    @(posedge clk); #1; bus_m.step = 1'b0;
    repeat (3) @(negedge clk);
    chk("step_pc", 64'(bus_m.pc), 64'(2));
    chk("step_busy", 64'(bus_m.busy), 64'(1));
    bus_m.step_mode = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus_m.done) break;
      @(negedge clk);
    end
    chk("step_done", 64'(bus_m.done), 64'(1));
    chk("step_err_code", 64'(bus_m.err_code), 64'(0));
    chk("step_count", 64'(bus_m.instr_count), 64'(3));
    pw(2, ins(12, 0, 0, 0, 0), 1);
    run_prog(0, 0, 0, 0);
    chk("new_word_code", 64'(bus_m.err_code), 64'(3));

    // Reset in the middle of an EXEC cycle
    pw(0, ins(1, 1, 2, 3, 0), 1);
    @(negedge clk); bus_m.start = 1'b1;
    @(posedge clk); #1; bus_m.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 64'(bus_m.busy), 64'(1));
    chk("pre_rst_count", 64'(bus_m.instr_count), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus_m.busy), 64'(0));
    chk("mid_rst_opcode", 64'(bus_m.opcode), 64'(0));
    chk("mid_rst_dest", 64'(bus_m.dest_reg), 64'(0));
    chk("mid_rst_count", 64'(bus_m.instr_count), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // Watchdog instance on an endless loop
    use_wd = 1;
    run_prog(0, 0, 0, 3);
    chk("wd_rw_pulses", 64'(rw_pulses), 64'(3));
    chk("wd_code", 64'(bus_w.err_code), 64'(4));
    chk("wd_count", 64'(bus_w.instr_count), 64'(3));
    use_wd = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
